// File: rtl/capi_mmio_doorbell_pkg.sv
// Shared constants and helpers for the multi-channel MMIO doorbell.
// Op select lives in the top word-address bit; per-channel params are packed LSB-first.
package capi_mmio_doorbell_pkg;

    localparam logic DB_OP_RING  = 1'b0;
    localparam logic DB_OP_CLEAR = 1'b1;

    typedef struct packed {
        logic ring;
        logic clr;
    } db_hit_t;

    // Channel c of a packed per-channel vector starts at bit c*width.
    function automatic int unsigned db_slice_lsb(input int unsigned chan, input int unsigned width);
        return chan * width;
    endfunction

endpackage

// File: rtl/capi_mmio_doorbell_chan.sv
// One doorbell channel: address decode, stage-1 hit registers, pending counter and sticky overflow.
module capi_mmio_doorbell_chan
    import capi_mmio_doorbell_pkg::*;
#(
    parameter int unsigned           addr_width = 25,
    parameter logic [addr_width-2:0] addr       = '0,
    parameter logic [addr_width-2:0] addr_mask  = '0,
    parameter int unsigned           cnt_width  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [addr_width-1:0] wa,
    input  logic                  we,
    input  logic                  trig_r,
    output logic                  trig,
    output logic                  trig_v,
    output logic [cnt_width-1:0]  pend_cnt,
    output logic                  ovf
);

    localparam logic [cnt_width-1:0] CNT_MAX = '1;

    db_hit_t              hit_d;
    db_hit_t              hit_q;
    logic                 match;
    logic                 pop;
    logic [cnt_width-1:0] cnt_q;
    logic                 ovf_q;

    assign match = ((~addr_mask & wa[addr_width-2:0]) == addr);

    always_comb begin
        hit_d = '0;
        if (we && match) begin
            hit_d.ring = (wa[addr_width-1] == DB_OP_RING);
            hit_d.clr  = (wa[addr_width-1] == DB_OP_CLEAR);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign pop = trig_v & trig_r;

    // A ring and a pop in the same edge cancel, so a saturated counter under
    // steady drain neither moves nor flags an overflow.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (hit_q.clr) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (hit_q.ring && pop) begin
            cnt_q <= cnt_q;
        end else if (hit_q.ring) begin
            if (cnt_q == CNT_MAX) begin
                ovf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (pop) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign trig     = hit_q.ring;
    assign trig_v   = (cnt_q != '0);
    assign pend_cnt = cnt_q;
    assign ovf      = ovf_q;

endmodule

// File: rtl/capi_mmio_doorbell.sv
// Multi-channel MMIO doorbell: one decoder/counter per channel, outputs packed LSB-first.
module capi_mmio_doorbell
    import capi_mmio_doorbell_pkg::*;
#(
    parameter int unsigned                         channels   = 4,
    parameter int unsigned                         addr_width = 25,
    parameter logic [channels*(addr_width-1)-1:0]  addrs      = '0,
    parameter logic [channels*(addr_width-1)-1:0]  addr_masks = '0,
    parameter int unsigned                         cnt_width  = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [addr_width-1:0]          wa,
    input  logic                           we,
    output logic [channels-1:0]            trig,
    output logic [channels-1:0]            trig_v,
    input  logic [channels-1:0]            trig_r,
    output logic [channels*cnt_width-1:0]  pend_cnt,
    output logic [channels-1:0]            ovf
);

    localparam int unsigned AB_W = addr_width - 1;

    for (genvar c = 0; c < channels; c++) begin : g_chan
        capi_mmio_doorbell_chan #(
            .addr_width (addr_width),
            .addr       (addrs[db_slice_lsb(c, AB_W) +: AB_W]),
            .addr_mask  (addr_masks[db_slice_lsb(c, AB_W) +: AB_W]),
            .cnt_width  (cnt_width)
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .wa       (wa),
            .we       (we),
            .trig_r   (trig_r[c]),
            .trig     (trig[c]),
            .trig_v   (trig_v[c]),
            .pend_cnt (pend_cnt[db_slice_lsb(c, cnt_width) +: cnt_width]),
            .ovf      (ovf[c])
        );
    end

endmodule
